fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 16'h0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, 16'h0000, instruction word presented to decode during a bubble.
REQ-003 clock  in  1  single clock; all state changes on posedge clock.
REQ-004 rst  in  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 stall  in  1  decode stage cannot accept; decode-side outputs hold.
REQ-006 branch_taken  in  1  redirect request from execute; flushes fetch.
REQ-007 branch_target  in  16  redirect address; bit 0 ignored (forced 0).
REQ-008 imem_req  out  1  instruction-memory request outstanding.
REQ-009 imem_addr  out  16  fetch address; stable while imem_req=1 and imem_ready=0.
REQ-010 imem_ready  in  1  imem_data valid this cycle; completes the outstanding request.
REQ-011 imem_data  in  16  returned instruction word.
REQ-012 decode_ir  out  16  registered instruction to decode.
REQ-013 decode_pc  out  16  registered address of decode_ir.
REQ-014 decode_valid  out  1  decode_ir/decode_pc hold a real instruction.

Function
REQ-015 States IDLE, WAIT, DRAIN, STALLED; at most one outstanding memory request.
REQ-016 IDLE: lasts exactly one cycle after reset release, imem_req=0; -> WAIT with pc=RESET_PC.
REQ-017 WAIT: imem_req=1, imem_addr=pc, held until imem_ready=1.
REQ-018 WAIT, imem_ready=1, stall=0: decode_ir<=imem_data, decode_pc<=pc, decode_valid<=1, pc<=pc+2; stay WAIT; next request issued the following cycle (one-cycle memory gives one instruction per cycle).
REQ-019 WAIT, imem_ready=1, stall=1: imem_data/pc captured in skid register, pc<=pc+2, decode outputs hold, -> STALLED.
REQ-020 WAIT, imem_ready=0, stall=0: decode_valid<=0, decode_ir<=NOP_INSTR, decode_pc holds.
REQ-021 Any state, stall=1, no branch: decode_ir/decode_pc/decode_valid hold.
REQ-022 STALLED: imem_req=0; on stall=0 skid contents move to decode outputs with decode_valid<=1, -> WAIT.
REQ-023 pc increment wraps 16'hFFFE -> 16'h0000, no flag.
REQ-024 branch_taken=1 has priority over stall and imem_ready: decode_valid<=0, decode_ir<=NOP_INSTR, skid cleared, pc<=branch_target & 16'hFFFE.
REQ-025 Branch in WAIT with imem_ready=0: -> DRAIN; DRAIN keeps imem_req=0, waits for imem_ready, discards imem_data, -> WAIT at target.
REQ-026 Branch in WAIT with imem_ready=1, or in STALLED/IDLE: returned/skid data discarded, -> WAIT at target next cycle.
REQ-027 Branch in DRAIN: target replaced by newest branch_target; stay DRAIN.
REQ-028 Every imem_ready=1 while imem_req=0 outside DRAIN is ignored.

Reset
REQ-029 rst=0 asynchronously forces: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, decode_ir=NOP_INSTR, decode_pc=16'h0000, decode_valid=0, skid empty.
REQ-030 Reset mid-request abandons the request; any imem_ready after release before first imem_req is ignored.

Structure
REQ-031 Shared package holds the state enum, NOP_INSTR default, and the PC increment constant 2.
REQ-032 One sub-module, fetch_skid_buffer (single entry, 16-bit ir + 16-bit pc + valid, async active-low reset); rest inline.

Verification
REQ-033 Reset release, imem_ready=1 every cycle -> decode_pc 0000,0002,0004 on consecutive cycles, decode_valid=1 from cycle 3.
REQ-034 imem_ready delayed 3 cycles on addr 0x0010 -> imem_addr stays 0x0010, decode_valid=0 and decode_ir=NOP_INSTR for those cycles.
REQ-035 stall=1 for 4 cycles as data 0xABCD returns -> decode outputs frozen, imem_req=0, on release decode_ir=0xABCD, decode_pc of that fetch.
REQ-036 branch_taken to 0x0101 while request pending -> DRAIN, returned word discarded, next imem_addr=0x0100, decode_valid=0 meanwhile.
REQ-037 branch_taken and stall and imem_ready same cycle -> decode_valid=0, next imem_addr=target; pc 0xFFFE fetch -> next imem_addr 0x0000.
REQ-038 rst pulsed low mid-WAIT -> all outputs at REQ-029 values immediately, first post-reset imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding, the default bubble word and the PC step.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_STALLED = 2'd3
  } fetch_state_t;

  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0000;
  localparam logic [15:0] PC_INC            = 16'd2;

  // Wraps 16'hFFFE -> 16'h0000 by plain modular arithmetic.
  function automatic logic [15:0] pc_incr(input logic [15:0] pc);
    return pc + PC_INC;
  endfunction

  function automatic logic [15:0] align_target(input logic [15:0] target);
    return target & 16'hFFFE;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch (master) and imem (slave).
// One request outstanding at a time; imem_ready completes it with imem_data.
interface fetch_unit_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_data
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// Single-entry holding register for a word that returned while decode was stalled.
// Loads in one cycle; clear wins over load so a flush always empties it.
module fetch_skid_buffer (
  input  logic        clock,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] fetch_ir,
  input  logic [15:0] fetch_pc,
  output logic [15:0] held_ir,
  output logic [15:0] held_pc,
  output logic        held_valid
);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      held_ir    <= 16'h0000;
      held_pc    <= 16'h0000;
      held_valid <= 1'b0;
    end else if (clear) begin
      held_ir    <= 16'h0000;
      held_pc    <= 16'h0000;
      held_valid <= 1'b0;
    end else if (load) begin
      held_ir    <= fetch_ir;
      held_pc    <= fetch_pc;
      held_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding imem request, registered decode outputs, 1 instr/cycle with 1-cycle memory.
// Stall freezes decode outputs (a returning word parks in the skid); branch flushes and redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [15:0]  branch_target,
  fetch_unit_if.master imem,
  output logic [15:0]  decode_ir,
  output logic [15:0]  decode_pc,
  output logic         decode_valid
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  target;
  logic [15:0]  pc_step;
  logic [15:0]  drain_pc;
  logic         skid_load;
  logic         skid_clear;
  logic [15:0]  skid_ir;
  logic [15:0]  skid_pc;
  logic         skid_valid;

  assign target   = align_target(branch_target);
  assign pc_step  = pc_incr(pc);
  assign drain_pc = branch_taken ? target : pc;

  assign skid_load  = (state == ST_WAIT) && imem.imem_ready && stall && !branch_taken;
  assign skid_clear = branch_taken || ((state == ST_STALLED) && !stall);

  fetch_skid_buffer u_skid (
    .clock      (clock),
    .rst        (rst),
    .load       (skid_load),
    .clear      (skid_clear),
    .fetch_ir   (imem.imem_data),
    .fetch_pc   (pc),
    .held_ir    (skid_ir),
    .held_pc    (skid_pc),
    .held_valid (skid_valid)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      pc             <= RESET_PC;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= RESET_PC;
      decode_ir      <= NOP_INSTR;
      decode_pc      <= 16'h0000;
      decode_valid   <= 1'b0;
    end else begin
      // A redirect always turns the decode slot into a bubble.
      if (branch_taken) begin
        decode_valid <= 1'b0;
        decode_ir    <= NOP_INSTR;
      end
      case (state)
        ST_IDLE: begin
          state          <= ST_WAIT;
          imem.imem_req  <= 1'b1;
          pc             <= branch_taken ? target : RESET_PC;
          imem.imem_addr <= branch_taken ? target : RESET_PC;
        end
        ST_WAIT: begin
          if (branch_taken) begin
            pc <= target;
            if (imem.imem_ready) begin
              imem.imem_addr <= target;
            end else begin
              state         <= ST_DRAIN;
              imem.imem_req <= 1'b0;
            end
          end else if (imem.imem_ready) begin
            pc <= pc_step;
            if (stall) begin
              state         <= ST_STALLED;
              imem.imem_req <= 1'b0;
            end else begin
              decode_ir      <= imem.imem_data;
              decode_pc      <= pc;
              decode_valid   <= 1'b1;
              imem.imem_addr <= pc_step;
            end
          end else if (!stall) begin
            decode_valid <= 1'b0;
            decode_ir    <= NOP_INSTR;
          end
        end
        ST_DRAIN: begin
          // The abandoned request's response is swallowed here.
          pc <= drain_pc;
          if (imem.imem_ready) begin
            state          <= ST_WAIT;
            imem.imem_req  <= 1'b1;
            imem.imem_addr <= drain_pc;
          end
        end
        ST_STALLED: begin
          if (branch_taken) begin
            pc             <= target;
            state          <= ST_WAIT;
            imem.imem_req  <= 1'b1;
            imem.imem_addr <= target;
          end else if (!stall) begin
            decode_ir      <= skid_ir;
            decode_pc      <= skid_pc;
            decode_valid   <= skid_valid;
            state          <= ST_WAIT;
            imem.imem_req  <= 1'b1;
            imem.imem_addr <= pc;
          end
        end
        default: begin
          state         <= ST_IDLE;
          imem.imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
